// File: rtl/systolic_skew_feeder_if.sv
// Operand, control and skewed-stream bundle for systolic_skew_feeder.
// stall_cnt exists only when SKEW_FEEDER_STALL_CNT_EN is defined.
interface systolic_skew_feeder_if #(
  parameter int LEN    = 4,
  parameter int DATA_W = 16,
  parameter int K_W    = 8
);
  logic                  start;
  logic [K_W-1:0]        k_len;
  logic                  busy;
  logic                  in_valid;
  logic                  in_ready;
  logic [LEN*DATA_W-1:0] a_vec;
  logic [LEN*DATA_W-1:0] b_vec;
  logic [LEN*DATA_W-1:0] row_data;
  logic [LEN-1:0]        row_valid;
  logic [LEN*DATA_W-1:0] col_data;
  logic [LEN-1:0]        col_valid;
  logic                  clear;
  logic                  done;
`ifdef SKEW_FEEDER_STALL_CNT_EN
  logic [15:0]           stall_cnt;
`endif

  modport master (
    output start, k_len, in_valid, a_vec, b_vec,
    input  busy, in_ready, row_data, row_valid, col_data, col_valid, clear, done
`ifdef SKEW_FEEDER_STALL_CNT_EN
    , input stall_cnt
`endif
  );

  modport slave (
    input  start, k_len, in_valid, a_vec, b_vec,
    output busy, in_ready, row_data, row_valid, col_data, col_valid, clear, done
`ifdef SKEW_FEEDER_STALL_CNT_EN
    , output stall_cnt
`endif
  );
endinterface

// File: rtl/systolic_skew_feeder.sv
// Skews per-k A/B operand vectors into diagonal row/column streams for the MAC array.
// Optional stall counter enabled by defining SKEW_FEEDER_STALL_CNT_EN.
module systolic_skew_feeder #(
  parameter int LEN    = 4,
  parameter int DATA_W = 16,
  parameter int K_W    = 8
) (
  input logic                  clk,
  input logic                  rst,
  systolic_skew_feeder_if.slave bus
);
  localparam int FW = (LEN > 2) ? $clog2(LEN - 1) : 1;

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, FLUSH, DONE} state_t;

  state_t         state;
  logic [K_W-1:0] k_reg;
  logic [K_W-1:0] beat_cnt;
  logic [FW-1:0]  flush_cnt;
  logic           accept;

  assign bus.in_ready = (state == FEED);
  assign bus.busy     = (state != IDLE);
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      k_reg     <= '0;
      beat_cnt  <= '0;
      flush_cnt <= '0;
      bus.clear <= 1'b0;
      bus.done  <= 1'b0;
    end else begin
      bus.clear <= 1'b0;
      bus.done  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            k_reg     <= bus.k_len;
            beat_cnt  <= '0;
            bus.clear <= 1'b1;
            state     <= CLEAR;
          end
        end
        CLEAR: begin
          if (k_reg == '0) begin
            bus.done <= 1'b1;
            state    <= DONE;
          end else begin
            state <= FEED;
          end
        end
        FEED: begin
          if (accept) begin
            beat_cnt <= beat_cnt + K_W'(1);
            if (beat_cnt == k_reg - K_W'(1)) begin
              flush_cnt <= '0;
              state     <= FLUSH;
            end
          end
        end
        // Wait for the last beat to reach lane LEN-1 so done lines up with it
        FLUSH: begin
          if (flush_cnt == FW'(LEN - 2)) begin
            bus.done <= 1'b1;
            state    <= DONE;
          end else begin
            flush_cnt <= flush_cnt + FW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SKEW_FEEDER_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.stall_cnt <= '0;
    end else if (state == CLEAR) begin
      bus.stall_cnt <= '0;
    end else if (state == FEED && !bus.in_valid && bus.stall_cnt != 16'hFFFF) begin
      bus.stall_cnt <= bus.stall_cnt + 16'd1;
    end
  end
`endif

  // Lane i holds i+1 stages; non-accepted cycles load {0,0} so bubbles skew like data
  for (genvar i = 0; i < LEN; i++) begin : g_lane
    logic [i:0]        row_v;
    logic [i:0]        col_v;
    logic [DATA_W-1:0] row_d [0:i];
    logic [DATA_W-1:0] col_d [0:i];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        row_v <= '0;
        col_v <= '0;
        for (int s = 0; s <= i; s++) begin
          row_d[s] <= '0;
          col_d[s] <= '0;
        end
      end else begin
        row_v[0] <= accept;
        col_v[0] <= accept;
        row_d[0] <= accept ? bus.a_vec[i*DATA_W +: DATA_W] : '0;
        col_d[0] <= accept ? bus.b_vec[i*DATA_W +: DATA_W] : '0;
        for (int s = 1; s <= i; s++) begin
          row_v[s] <= row_v[s-1];
          col_v[s] <= col_v[s-1];
          row_d[s] <= row_d[s-1];
          col_d[s] <= col_d[s-1];
        end
      end
    end

    assign bus.row_data[i*DATA_W +: DATA_W] = row_d[i];
    assign bus.col_data[i*DATA_W +: DATA_W] = col_d[i];
    assign bus.row_valid[i]                 = row_v[i];
    assign bus.col_valid[i]                 = col_v[i];
  end
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Self-checking bench for systolic_skew_feeder against a cycle-timestamp reference model.
// Stall counter checks compile in when SKEW_FEEDER_STALL_CNT_EN is defined.
module tb_systolic_skew_feeder;
  localparam int LEN    = 4;
  localparam int DATA_W = 16;
  localparam int K_W    = 8;
  localparam int W      = LEN * DATA_W;
  localparam int VW     = 2 * LEN + 2 * W + 4;
  localparam int HN     = 4096;

  logic clk;
  logic rst;

  systolic_skew_feeder_if #(.LEN(LEN), .DATA_W(DATA_W), .K_W(K_W)) bus ();

  systolic_skew_feeder #(.LEN(LEN), .DATA_W(DATA_W), .K_W(K_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: acc_h[c] means a beat was accepted on the edge closing cycle c;
  // lane i then shows it during cycle c+1+i.
  bit         acc_h [0:HN-1];
  logic [W-1:0] a_h [0:HN-1];
  logic [W-1:0] b_h [0:HN-1];
  int cyc, clear_at, done_at, feed_from, left;
  int n_vec, n_err;
`ifdef SKEW_FEEDER_STALL_CNT_EN
  int stall_exp;
`endif

  function automatic bit model_idle(int c);
    return (clear_at < 0) || (done_at >= 0 && c > done_at);
  endfunction

  function automatic bit model_ready(int c);
    return !model_idle(c) && feed_from >= 0 && c >= feed_from && left > 0;
  endfunction

  function automatic logic [VW-1:0] exp_vec(int c);
    logic [LEN-1:0] rv, cv;
    logic [W-1:0]   rd, cd;
    int idx;
    rv = '0; cv = '0; rd = '0; cd = '0;
    for (int i = 0; i < LEN; i++) begin
      idx = c - 1 - i;
      if (idx >= 0 && acc_h[idx]) begin
        rv[i] = 1'b1;
        cv[i] = 1'b1;
        rd[i*DATA_W +: DATA_W] = a_h[idx][i*DATA_W +: DATA_W];
        cd[i*DATA_W +: DATA_W] = b_h[idx][i*DATA_W +: DATA_W];
      end
    end
    return {rv, rd, cv, cd, model_ready(c), !model_idle(c), (c == clear_at), (c == done_at)};
  endfunction

  function automatic logic [VW-1:0] got_vec();
    return {bus.row_valid, bus.row_data, bus.col_valid, bus.col_data,
            bus.in_ready, bus.busy, bus.clear, bus.done};
  endfunction

  function automatic logic [W-1:0] rand_vec();
    logic [W-1:0] v;
    for (int i = 0; i < LEN; i++) v[i*DATA_W +: DATA_W] = DATA_W'($urandom);
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < HN; i++) acc_h[i] = 1'b0;
    clear_at = -1; done_at = -1; feed_from = -1; left = 0;
`ifdef SKEW_FEEDER_STALL_CNT_EN
    stall_exp = 0;
`endif
  endtask

  // Records what the model expects this cycle, then advances one clock
  task automatic tick();
    bit rdy;
    rdy        = model_ready(cyc);
    acc_h[cyc] = rdy && bus.in_valid;
    a_h[cyc]   = bus.a_vec;
    b_h[cyc]   = bus.b_vec;
`ifdef SKEW_FEEDER_STALL_CNT_EN
    if (cyc == clear_at) stall_exp = 0;
    else if (rdy && !bus.in_valid && stall_exp < 65535) stall_exp++;
`endif
    if (acc_h[cyc]) begin
      left--;
      if (left == 0) done_at = cyc + LEN;
    end
    if (bus.start && model_idle(cyc)) begin
      clear_at  = cyc + 1;
      feed_from = cyc + 2;
      left      = int'(bus.k_len);
      done_at   = (left == 0) ? cyc + 2 : -1;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic assert_reset();
    #2;
    rst = 1'b1;
    model_clear();
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    logic [VW-1:0] got, exp;
    rst = 1'b1;
    bus.start = 1'b0; bus.k_len = '0; bus.in_valid = 1'b0;
    bus.a_vec = '0; bus.b_vec = '0;
    model_clear();
    #2;
    n_vec++;
    if (got_vec() !== '0) begin
      n_err++; $display("[TB] FAIL reset_outputs got=%h exp=0", got_vec());
    end
`ifdef SKEW_FEEDER_STALL_CNT_EN
    n_vec++;
    if (bus.stall_cnt !== 16'd0) begin
      n_err++; $display("[TB] FAIL reset_stall got=%0d exp=0", bus.stall_cnt);
    end
`endif
    release_reset();
    for (int n = 0; n < 3; n++) begin
      bus.in_valid = 1'b1; bus.a_vec = rand_vec(); bus.b_vec = rand_vec();
      got = got_vec(); exp = exp_vec(cyc); n_vec++;
      if (got !== exp) begin
        n_err++; $display("[TB] FAIL idle cyc=%0d got=%h exp=%h", cyc, got, exp);
      end
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_basic();
    logic [VW-1:0] got, exp;
    int flush_seen, done_seen, b;
    flush_seen = 0; done_seen = 0;
    bus.start = 1'b1; bus.k_len = K_W'(3);
    tick();
    bus.start = 1'b0; bus.k_len = K_W'($urandom);
    for (int n = 0; n < 14; n++) begin
      b = 3 - left;
      if (b > 2) b = 2;
      bus.in_valid = 1'b1;
      for (int i = 0; i < LEN; i++) bus.a_vec[i*DATA_W +: DATA_W] = DATA_W'(4 * b + i + 1);
      bus.b_vec = rand_vec();
      got = got_vec(); exp = exp_vec(cyc); n_vec++;
      if (got !== exp) begin
        n_err++; $display("[TB] FAIL basic cyc=%0d got=%h exp=%h", cyc, got, exp);
      end
      if (bus.busy && !bus.in_ready && !bus.clear && !bus.done) flush_seen++;
      if (bus.done) begin
        done_seen++; n_vec++;
        if (bus.row_data[3*DATA_W +: DATA_W] !== 16'd12) begin
          n_err++; $display("[TB] FAIL basic_done_lane3 got=%0d exp=12", bus.row_data[3*DATA_W +: DATA_W]);
        end
      end
      if (cyc >= feed_from + 1 && cyc <= feed_from + 3) begin
        n_vec++;
        if (bus.row_data[DATA_W-1:0] !== DATA_W'(1 + 4 * (cyc - feed_from - 1))) begin
          n_err++; $display("[TB] FAIL basic_lane0 cyc=%0d got=%0d", cyc, bus.row_data[DATA_W-1:0]);
        end
      end
      tick();
    end
    bus.in_valid = 1'b0;
    n_vec++;
    if (flush_seen !== 3) begin
      n_err++; $display("[TB] FAIL basic_flush_cycles got=%0d exp=3", flush_seen);
    end
    n_vec++;
    if (done_seen !== 1) begin
      n_err++; $display("[TB] FAIL basic_done_count got=%0d exp=1", done_seen);
    end
  endtask

  task automatic test_zero();
    logic [VW-1:0] got, exp;
    int ready_seen, done_seen, valid_seen;
    ready_seen = 0; done_seen = 0; valid_seen = 0;
    bus.start = 1'b1; bus.k_len = '0;
    tick();
    bus.start = 1'b0;
    for (int n = 0; n < 6; n++) begin
      bus.in_valid = 1'($urandom); bus.a_vec = rand_vec(); bus.b_vec = rand_vec();
      got = got_vec(); exp = exp_vec(cyc); n_vec++;
      if (got !== exp) begin
        n_err++; $display("[TB] FAIL zero cyc=%0d got=%h exp=%h", cyc, got, exp);
      end
      if (bus.in_ready) ready_seen++;
      if (bus.done) done_seen++;
      if (|{bus.row_valid, bus.col_valid}) valid_seen++;
      tick();
    end
    bus.in_valid = 1'b0;
    n_vec++;
    if (ready_seen !== 0 || valid_seen !== 0 || done_seen !== 1) begin
      n_err++;
      $display("[TB] FAIL zero_summary ready=%0d valid=%0d done=%0d exp 0/0/1", ready_seen, valid_seen, done_seen);
    end
  endtask

  task automatic test_bubble();
    logic [VW-1:0] got, exp;
    int f, clear_cyc, done_cyc;
    clear_cyc = -100; done_cyc = -1;
    bus.start = 1'b1; bus.k_len = K_W'(4);
    tick();
    bus.start = 1'b0;
    for (int n = 0; n < 16; n++) begin
      f = cyc - feed_from;
      bus.in_valid = !(f == 2 || f == 3);
      bus.a_vec = rand_vec(); bus.b_vec = rand_vec();
      got = got_vec(); exp = exp_vec(cyc); n_vec++;
      if (got !== exp) begin
        n_err++; $display("[TB] FAIL bubble cyc=%0d got=%h exp=%h", cyc, got, exp);
      end
      if (bus.clear) clear_cyc = cyc;
      if (bus.done) done_cyc = cyc;
      tick();
    end
    bus.in_valid = 1'b0;
    n_vec++;
    if (done_cyc - clear_cyc !== 6 + LEN) begin
      n_err++; $display("[TB] FAIL bubble_done_delay got=%0d exp=%0d", done_cyc - clear_cyc, 6 + LEN);
    end
`ifdef SKEW_FEEDER_STALL_CNT_EN
    n_vec++;
    if (bus.stall_cnt !== 16'd2) begin
      n_err++; $display("[TB] FAIL bubble_stall got=%0d exp=2", bus.stall_cnt);
    end
`endif
  endtask

  task automatic test_start_ignored();
    logic [VW-1:0] got, exp;
    int done_seen, beats_seen;
    done_seen = 0; beats_seen = 0;
    bus.start = 1'b1; bus.k_len = K_W'(5);
    tick();
    for (int n = 0; n < 40; n++) begin
      bus.start    = !model_idle(cyc) && 1'($urandom);
      bus.k_len    = K_W'($urandom);
      bus.in_valid = (cyc - feed_from > 12) || ($urandom_range(0, 3) != 0);
      bus.a_vec = rand_vec(); bus.b_vec = rand_vec();
      got = got_vec(); exp = exp_vec(cyc); n_vec++;
      if (got !== exp) begin
        n_err++; $display("[TB] FAIL start_ignored cyc=%0d got=%h exp=%h", cyc, got, exp);
      end
      if (bus.done) done_seen++;
      if (bus.in_ready && bus.in_valid) beats_seen++;
      tick();
    end
    bus.start = 1'b0; bus.in_valid = 1'b0;
    n_vec++;
    if (done_seen !== 1 || beats_seen !== 5) begin
      n_err++; $display("[TB] FAIL start_ignored_summary done=%0d beats=%0d exp 1/5", done_seen, beats_seen);
    end
  endtask

  task automatic test_reset_mid();
    logic [VW-1:0] got, exp;
    int done_seen;
    done_seen = 0;
    bus.start = 1'b1; bus.k_len = K_W'(5);
    tick();
    bus.start = 1'b0;
    for (int n = 0; n < 10 && left != 3; n++) begin
      bus.in_valid = 1'b1; bus.a_vec = rand_vec(); bus.b_vec = rand_vec();
      got = got_vec(); exp = exp_vec(cyc); n_vec++;
      if (got !== exp) begin
        n_err++; $display("[TB] FAIL reset_mid_pre cyc=%0d got=%h exp=%h", cyc, got, exp);
      end
      tick();
    end
    assert_reset();
    n_vec++;
    if (got_vec() !== '0) begin
      n_err++; $display("[TB] FAIL reset_mid_outputs got=%h exp=0", got_vec());
    end
`ifdef SKEW_FEEDER_STALL_CNT_EN
    n_vec++;
    if (bus.stall_cnt !== 16'd0) begin
      n_err++; $display("[TB] FAIL reset_mid_stall got=%0d exp=0", bus.stall_cnt);
    end
`endif
    release_reset();
    for (int n = 0; n < 8; n++) begin
      bus.in_valid = 1'b1; bus.a_vec = rand_vec(); bus.b_vec = rand_vec();
      got = got_vec(); exp = exp_vec(cyc); n_vec++;
      if (got !== exp) begin
        n_err++; $display("[TB] FAIL reset_mid_after cyc=%0d got=%h exp=%h", cyc, got, exp);
      end
      if (bus.done) done_seen++;
      tick();
    end
    bus.start = 1'b1; bus.k_len = K_W'(5);
    tick();
    bus.start = 1'b0;
    for (int n = 0; n < 16; n++) begin
      bus.in_valid = 1'b1; bus.a_vec = rand_vec(); bus.b_vec = rand_vec();
      got = got_vec(); exp = exp_vec(cyc); n_vec++;
      if (got !== exp) begin
        n_err++; $display("[TB] FAIL reset_mid_tile cyc=%0d got=%h exp=%h", cyc, got, exp);
      end
      if (bus.done) done_seen++;
      tick();
    end
    bus.in_valid = 1'b0;
    n_vec++;
    if (done_seen !== 1) begin
      n_err++; $display("[TB] FAIL reset_mid_done_count got=%0d exp=1", done_seen);
    end
  endtask

  task automatic test_back_to_back();
    logic [VW-1:0] got, exp;
    int tiles, done_seen, first_done, second_clear;
    tiles = 0; done_seen = 0; first_done = -1; second_clear = -1;
    for (int n = 0; n < 24; n++) begin
      bus.start = (tiles < 2) && model_idle(cyc);
      bus.k_len = K_W'(2);
      if (bus.start) tiles++;
      bus.in_valid = 1'b1; bus.a_vec = rand_vec(); bus.b_vec = rand_vec();
      got = got_vec(); exp = exp_vec(cyc); n_vec++;
      if (got !== exp) begin
        n_err++; $display("[TB] FAIL back_to_back cyc=%0d got=%h exp=%h", cyc, got, exp);
      end
      if (bus.done) begin
        done_seen++;
        if (first_done < 0) first_done = cyc;
      end
      if (bus.clear && first_done >= 0) second_clear = cyc;
      tick();
    end
    bus.start = 1'b0; bus.in_valid = 1'b0;
    n_vec++;
    if (done_seen !== 2 || second_clear - first_done !== 2) begin
      n_err++;
      $display("[TB] FAIL back_to_back_gap done=%0d gap=%0d exp 2/2", done_seen, second_clear - first_done);
    end
  endtask

  task automatic test_random();
    logic [VW-1:0] got, exp;
    for (int n = 0; n < 320; n++) begin
      bus.start    = (n < 300) && model_idle(cyc) && ($urandom_range(0, 2) == 0);
      bus.k_len    = K_W'($urandom_range(0, 6));
      bus.in_valid = (n >= 300) || ($urandom_range(0, 3) != 0);
      bus.a_vec = rand_vec(); bus.b_vec = rand_vec();
      got = got_vec(); exp = exp_vec(cyc); n_vec++;
      if (got !== exp) begin
        n_err++; $display("[TB] FAIL random cyc=%0d got=%h exp=%h", cyc, got, exp);
      end
`ifdef SKEW_FEEDER_STALL_CNT_EN
      n_vec++;
      if (bus.stall_cnt !== 16'(stall_exp)) begin
        n_err++; $display("[TB] FAIL random_stall cyc=%0d got=%0d exp=%0d", cyc, bus.stall_cnt, stall_exp);
      end
`endif
      tick();
    end
    bus.start = 1'b0; bus.in_valid = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_err = 0; cyc = 0;
    test_reset();
    test_basic();
    test_zero();
    test_bubble();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog time limit reached");
    $fatal(1, "[TB] watchdog");
  end
endmodule
